// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux arbiter.
package rr_mux_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot grant pattern for a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_mux_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_mux_if;
  import rr_mux_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   sel;
  logic               busy;
  logic               preempt;

  modport master (output req, input gnt, sel, busy, preempt);
  modport slave  (input req, output gnt, sel, busy, preempt);

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping 3->0.
module rr_pick4
  import rr_mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk the four positions starting at ptr; index arithmetic wraps for free at IDX_W bits.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 4:1 mux,
// with a max-hold timeout so no requester can keep the mux indefinitely.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input logic     clk,
  input logic     rst_n,
  rr_mux_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   ptr, ptr_next;
  logic [IDX_W-1:0]   sel_q, sel_next;
  logic [NUM_REQ-1:0] gnt_q, gnt_next;
  logic [HOLD_W-1:0]  hold_cnt, hold_next;
  logic               busy_q, busy_next;
  logic               pre_q, pre_next;

  logic               req_held;
  logic               at_limit;
  logic               release_now;
  logic [IDX_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  // A releasing grant re-arbitrates on the same edge from the slot after the current owner.
  assign req_held    = bus.req[sel_q];
  assign at_limit    = (hold_cnt == HOLD_LAST);
  assign release_now = (state == GRANT) && (!req_held || at_limit);
  assign pick_ptr    = release_now ? sel_q + IDX_W'(1) : ptr;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and registered-output decode for the IDLE/GRANT machine.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sel_next   = sel_q;
    gnt_next   = gnt_q;
    busy_next  = busy_q;
    hold_next  = hold_cnt;
    pre_next   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          gnt_next   = onehot(pick_idx);
          sel_next   = pick_idx;
          busy_next  = 1'b1;
          hold_next  = '0;
        end
      end
      GRANT: begin
        if (!release_now) begin
          hold_next = hold_cnt + HOLD_W'(1);
        end else begin
          ptr_next  = pick_ptr;
          // A release with the request still high can only be the timeout.
          pre_next  = req_held;
          hold_next = '0;
          if (pick_found) begin
            gnt_next = onehot(pick_idx);
            sel_next = pick_idx;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            busy_next  = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointer, hold counter and output registers; all clear asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      sel_q    <= '0;
      gnt_q    <= '0;
      hold_cnt <= '0;
      busy_q   <= 1'b0;
      pre_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_next;
      ptr      <= ptr_next;
      sel_q    <= sel_next;
      gnt_q    <= gnt_next;
      hold_cnt <= hold_next;
      busy_q   <= busy_next;
      pre_q    <= pre_next;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = pre_q;

endmodule
